// File: rtl/alu_muldiv_if.sv
// Reservation-station <-> execution-unit link for alu_muldiv_unit.
// Master (RS side) drives the global ready, flush and dispatch fields.
// Slave (execution unit) drives busy and the result-bus broadcast.
//   rdy, rollback                  : global ready / mispredict flush
//   in_en, in_val1/2, in_imm, in_pc: dispatch valid and operands
//   in_opcode/funct3/funct7/muldiv : decoded op fields
//   in_rob_pos                     : destination ROB tag
//   busy                           : combinational back-pressure to RS
//   result, result_val/rob_pos/jump/pc : registered result-bus broadcast
interface alu_muldiv_if #(
   parameter int unsigned ROB_POS_W = 4
);
   logic                 rdy;
   logic                 rollback;
   logic                 in_en;
   logic [31:0]          in_val1;
   logic [31:0]          in_val2;
   logic [31:0]          in_imm;
   logic [31:0]          in_pc;
   logic [6:0]           in_opcode;
   logic [2:0]           in_funct3;
   logic                 in_funct7;
   logic                 in_muldiv;
   logic [ROB_POS_W-1:0] in_rob_pos;

   logic                 busy;
   logic                 result;
   logic [31:0]          result_val;
   logic [ROB_POS_W-1:0] result_rob_pos;
   logic                 result_jump;
   logic [31:0]          result_pc;

   modport master (
      output rdy, rollback, in_en, in_val1, in_val2, in_imm, in_pc,
             in_opcode, in_funct3, in_funct7, in_muldiv, in_rob_pos,
      input  busy, result, result_val, result_rob_pos, result_jump, result_pc
   );

   modport slave (
      input  rdy, rollback, in_en, in_val1, in_val2, in_imm, in_pc,
             in_opcode, in_funct3, in_funct7, in_muldiv, in_rob_pos,
      output busy, result, result_val, result_rob_pos, result_jump, result_pc
   );
endinterface

// File: rtl/alu_muldiv_unit.sv
// RV32I/RV32M execution unit. Single-cycle integer, branch and jump ops
// complete on the accept edge; MUL* take MUL_LAT cycles, DIV/REM* run a
// 32-step restoring divider plus a sign-correction edge.
// Ports:
//   clk  : clock, posedge
//   rst  : asynchronous active-high reset
//   bus  : alu_muldiv_if.slave (dispatch in, busy + result bus out)
module alu_muldiv_unit #(
   parameter int unsigned ROB_POS_W = 4,
   parameter int unsigned MUL_LAT   = 3
) (
   input logic         clk,
   input logic         rst,
   alu_muldiv_if.slave bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 6;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [CNT_W-1:0] MUL_INIT  = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_STEPS = CNT_W'(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]      op_a_q, op_a_d;     // MUL: rs1; DIV: original dividend
   logic [XLEN-1:0]      op_b_q, op_b_d;     // MUL: rs2; DIV: divisor magnitude
   logic [1:0]           f3_q, f3_d;
   logic [ROB_POS_W-1:0] rob_q, rob_d;
   logic [XLEN-1:0]      pc4_q, pc4_d;
   logic [XLEN-1:0]      rem_q, rem_d;
   logic [XLEN-1:0]      quo_q, quo_d;
   logic                 neg_quo_q, neg_quo_d;
   logic                 neg_rem_q, neg_rem_d;

   logic                 res_q, res_d;
   logic [XLEN-1:0]      res_val_q, res_val_d;
   logic [ROB_POS_W-1:0] res_rob_q, res_rob_d;
   logic                 res_jump_q, res_jump_d;
   logic [XLEN-1:0]      res_pc_q, res_pc_d;

   logic                 is_op;
   logic                 is_muldiv_c;
   logic [XLEN-1:0]      alu_b, pc4, alu_val, alu_pc;
   logic [4:0]           shamt;
   logic                 alu_jump, br_taken;

   logic                 mul_sa, mul_sb;
   logic [2*XLEN-1:0]    mul_prod;
   logic [XLEN-1:0]      mul_res;

   logic [XLEN:0]        div_sh;
   logic                 div_ge;
   logic [XLEN-1:0]      div_quo_fin, div_rem_fin;

   assign is_op       = (bus.in_opcode == OPC_OP);
   assign is_muldiv_c = bus.in_en & bus.in_muldiv & is_op;
   assign bus.busy    = (state_q != S_IDLE) | is_muldiv_c;

   assign bus.result         = res_q;
   assign bus.result_val     = res_val_q;
   assign bus.result_rob_pos = res_rob_q;
   assign bus.result_jump    = res_jump_q;
   assign bus.result_pc      = res_pc_q;

   // Single-cycle integer / control datapath
   always_comb begin
      alu_b    = is_op ? bus.in_val2 : bus.in_imm;
      shamt    = alu_b[4:0];
      pc4      = bus.in_pc + 32'd4;
      alu_val  = '0;
      alu_jump = 1'b0;
      alu_pc   = pc4;
      br_taken = 1'b0;
      case (bus.in_opcode)
         OPC_OP, OPC_OPIMM: begin
            case (bus.in_funct3)
               3'b000: alu_val = (is_op && bus.in_funct7) ? bus.in_val1 - alu_b
                                                          : bus.in_val1 + alu_b;
               3'b001: alu_val = bus.in_val1 << shamt;
               3'b010: alu_val = {31'd0, $signed(bus.in_val1) < $signed(alu_b)};
               3'b011: alu_val = {31'd0, bus.in_val1 < alu_b};
               3'b100: alu_val = bus.in_val1 ^ alu_b;
               3'b101: alu_val = bus.in_funct7 ? 32'($signed(bus.in_val1) >>> shamt)
                                               : bus.in_val1 >> shamt;
               3'b110: alu_val = bus.in_val1 | alu_b;
               default: alu_val = bus.in_val1 & alu_b;
            endcase
         end
         OPC_LUI:   alu_val = bus.in_imm;
         OPC_AUIPC: alu_val = bus.in_pc + bus.in_imm;
         OPC_JAL: begin
            alu_val  = pc4;
            alu_jump = 1'b1;
            alu_pc   = bus.in_pc + bus.in_imm;
         end
         OPC_JALR: begin
            alu_val  = pc4;
            alu_jump = 1'b1;
            alu_pc   = (bus.in_val1 + bus.in_imm) & ~32'd1;
         end
         OPC_BRANCH: begin
            case (bus.in_funct3)
               3'b000:  br_taken = (bus.in_val1 == bus.in_val2);
               3'b001:  br_taken = (bus.in_val1 != bus.in_val2);
               3'b100:  br_taken = ($signed(bus.in_val1) <  $signed(bus.in_val2));
               3'b101:  br_taken = ($signed(bus.in_val1) >= $signed(bus.in_val2));
               3'b110:  br_taken = (bus.in_val1 <  bus.in_val2);
               3'b111:  br_taken = (bus.in_val1 >= bus.in_val2);
               default: br_taken = 1'b0;
            endcase
            alu_jump = br_taken;
            alu_pc   = br_taken ? bus.in_pc + bus.in_imm : pc4;
         end
         default: ;
      endcase
   end

   // Multiplier: sign-extend to 64 bits per funct3, keep low or high word
   always_comb begin
      mul_sa   = (f3_q != 2'b11);
      mul_sb   = (f3_q == 2'b01);
      mul_prod = {{XLEN{mul_sa & op_a_q[XLEN-1]}}, op_a_q} *
                 {{XLEN{mul_sb & op_b_q[XLEN-1]}}, op_b_q};
      mul_res  = (f3_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
   end

   // Divider step and final sign correction; divide-by-zero overrides
   always_comb begin
      div_sh      = {rem_q, quo_q[XLEN-1]};
      div_ge      = (div_sh >= {1'b0, op_b_q});
      div_quo_fin = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
      div_rem_fin = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
      if (op_b_q == '0) begin
         div_quo_fin = '1;
         div_rem_fin = op_a_q;
      end
   end

   // Next-state and result-bus logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      f3_d       = f3_q;
      rob_d      = rob_q;
      pc4_d      = pc4_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      res_d      = res_q;
      res_val_d  = res_val_q;
      res_rob_d  = res_rob_q;
      res_jump_d = res_jump_q;
      res_pc_d   = res_pc_q;

      if (bus.rollback) begin
         state_d = S_IDLE;
         res_d   = 1'b0;
      end else if (bus.rdy) begin
         res_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.in_en) begin
                  rob_d  = bus.in_rob_pos;
                  pc4_d  = pc4;
                  f3_d   = bus.in_funct3[1:0];
                  op_a_d = bus.in_val1;
                  op_b_d = bus.in_val2;
                  if (is_muldiv_c && !bus.in_funct3[2]) begin
                     state_d = S_MUL;
                     cnt_d   = MUL_INIT;
                  end else if (is_muldiv_c) begin
                     // funct3[0]=0 selects the signed DIV/REM forms
                     state_d   = S_DIV;
                     cnt_d     = DIV_STEPS;
                     rem_d     = '0;
                     quo_d     = (!bus.in_funct3[0] && bus.in_val1[XLEN-1])
                                 ? (~bus.in_val1 + 32'd1) : bus.in_val1;
                     op_b_d    = (!bus.in_funct3[0] && bus.in_val2[XLEN-1])
                                 ? (~bus.in_val2 + 32'd1) : bus.in_val2;
                     neg_quo_d = !bus.in_funct3[0] & (bus.in_val1[XLEN-1] ^ bus.in_val2[XLEN-1]);
                     neg_rem_d = !bus.in_funct3[0] & bus.in_val1[XLEN-1];
                  end else begin
                     res_d      = 1'b1;
                     res_val_d  = alu_val;
                     res_rob_d  = bus.in_rob_pos;
                     res_jump_d = alu_jump;
                     res_pc_d   = alu_pc;
                  end
               end
            end
            S_MUL: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d    = S_IDLE;
                  res_d      = 1'b1;
                  res_val_d  = mul_res;
                  res_rob_d  = rob_q;
                  res_jump_d = 1'b0;
                  res_pc_d   = pc4_q;
               end
            end
            S_DIV: begin
               if (cnt_q == '0) begin
                  state_d    = S_IDLE;
                  res_d      = 1'b1;
                  res_val_d  = f3_q[1] ? div_rem_fin : div_quo_fin;
                  res_rob_d  = rob_q;
                  res_jump_d = 1'b0;
                  res_pc_d   = pc4_q;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  quo_d = {quo_q[XLEN-2:0], div_ge};
                  rem_d = div_ge ? XLEN'(div_sh - {1'b0, op_b_q}) : div_sh[XLEN-1:0];
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         f3_q       <= '0;
         rob_q      <= '0;
         pc4_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         res_q      <= 1'b0;
         res_val_q  <= '0;
         res_rob_q  <= '0;
         res_jump_q <= 1'b0;
         res_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         f3_q       <= f3_d;
         rob_q      <= rob_d;
         pc4_q      <= pc4_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         res_q      <= res_d;
         res_val_q  <= res_val_d;
         res_rob_q  <= res_rob_d;
         res_jump_q <= res_jump_d;
         res_pc_q   <= res_pc_d;
      end
   end
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: vector table plus multi-cycle corner sequences.
module tb_alu_muldiv_unit;
   localparam int unsigned ROB_POS_W = 4;
   localparam int unsigned MUL_LAT   = 3;
   localparam int DIV_LAT = 33;   // edges after the accept edge

   localparam logic [6:0] OP  = 7'h33;
   localparam logic [6:0] OPI = 7'h13;
   localparam logic [6:0] LUI = 7'h37;
   localparam logic [6:0] AUI = 7'h17;
   localparam logic [6:0] JAL = 7'h6F;
   localparam logic [6:0] JLR = 7'h67;
   localparam logic [6:0] BR  = 7'h63;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   alu_muldiv_if #(.ROB_POS_W(ROB_POS_W)) bus ();

   alu_muldiv_unit #(.ROB_POS_W(ROB_POS_W), .MUL_LAT(MUL_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic        md;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [3:0]  rob;
      logic [31:0] e_val;
      logic        e_jump;
      logic [31:0] e_pc;
      int          e_lat;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(string nm, logic [6:0] opc, logic [2:0] f3, logic f7, logic md,
                               logic [31:0] v1, logic [31:0] v2, logic [31:0] imm, logic [31:0] pc,
                               logic [3:0] rob, logic [31:0] ev, logic ej, logic [31:0] ep, int el);
      vec_t v;
      v.name = nm; v.opc = opc; v.f3 = f3; v.f7 = f7; v.md = md;
      v.v1 = v1; v.v2 = v2; v.imm = imm; v.pc = pc; v.rob = rob;
      v.e_val = ev; v.e_jump = ej; v.e_pc = ep; v.e_lat = el;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.in_opcode  = v.opc;
      bus.in_funct3  = v.f3;
      bus.in_funct7  = v.f7;
      bus.in_muldiv  = v.md;
      bus.in_val1    = v.v1;
      bus.in_val2    = v.v2;
      bus.in_imm     = v.imm;
      bus.in_pc      = v.pc;
      bus.in_rob_pos = v.rob;
   endtask

   // Counts edges after the accept edge until result is seen, bounded by max
   task automatic wait_result(input int start, input int max, output int edges);
      edges = start;
      while (!bus.result && edges < max) begin
         step();
         edges++;
      end
   endtask

   task automatic run_vec(input vec_t v);
      int e;
      drive(v);
      bus.in_en = 1'b1;
      step();
      bus.in_en = 1'b0;
      wait_result(0, 60, e);
      chk({v.name, " result"}, 32'(bus.result), 32'd1);
      chk({v.name, " latency"}, 32'(e), 32'(v.e_lat));
      chk({v.name, " val"}, bus.result_val, v.e_val);
      chk({v.name, " jump"}, 32'(bus.result_jump), 32'(v.e_jump));
      chk({v.name, " pc"}, bus.result_pc, v.e_pc);
      chk({v.name, " rob"}, 32'(bus.result_rob_pos), 32'(v.rob));
      step();
      chk({v.name, " pulse_end"}, 32'(bus.result), 32'd0);
   endtask

   initial begin
      int   e;
      int   cnt;
      vec_t v;

      rst = 1'b1;
      bus.rdy = 1'b1;
      bus.rollback = 1'b0;
      bus.in_en = 1'b0;
      drive(mk("z", 7'd0, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0, 4'd0, 0, 1'b0, 0, 0));

      vq.push_back(mk("add",    OP,  3'd0, 1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, 32'h10, 4'd5, 32'd4, 1'b0, 32'h14, 0));
      vq.push_back(mk("sub",    OP,  3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 0, 32'h20, 4'd1, 32'hFFFF_FFFE, 1'b0, 32'h24, 0));
      vq.push_back(mk("addi_f7",OPI, 3'd0, 1'b1, 1'b0, 32'd10, 32'd99, 32'hFFFF_FFFF, 32'h30, 4'd2, 32'd9, 1'b0, 32'h34, 0));
      vq.push_back(mk("srai",   OPI, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'h404, 32'h40, 4'd3, 32'hF800_0000, 1'b0, 32'h44, 0));
      vq.push_back(mk("srl",    OP,  3'd5, 1'b0, 1'b0, 32'h8000_0000, 32'h21, 0, 32'h50, 4'd4, 32'h4000_0000, 1'b0, 32'h54, 0));
      vq.push_back(mk("slt",    OP,  3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 32'h60, 4'd6, 32'd1, 1'b0, 32'h64, 0));
      vq.push_back(mk("sltu",   OP,  3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 32'h60, 4'd7, 32'd0, 1'b0, 32'h64, 0));
      vq.push_back(mk("lui",    LUI, 3'd0, 1'b0, 1'b0, 0, 0, 32'h1234_5000, 32'h70, 4'd8, 32'h1234_5000, 1'b0, 32'h74, 0));
      vq.push_back(mk("auipc",  AUI, 3'd0, 1'b0, 1'b0, 0, 0, 32'h2000, 32'h1000, 4'd9, 32'h3000, 1'b0, 32'h1004, 0));
      vq.push_back(mk("jal",    JAL, 3'd0, 1'b0, 1'b0, 0, 0, 32'h10, 32'h200, 4'd10, 32'h204, 1'b1, 32'h210, 0));
      vq.push_back(mk("jalr",   JLR, 3'd0, 1'b0, 1'b0, 32'h1001, 0, 32'd4, 32'h40, 4'd11, 32'h44, 1'b1, 32'h1004, 0));
      vq.push_back(mk("blt_t",  BR,  3'd4, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd12, 32'd0, 1'b1, 32'h120, 0));
      vq.push_back(mk("blt_nt", BR,  3'd4, 1'b0, 1'b0, 32'd2, 32'd1, 32'h20, 32'h100, 4'd13, 32'd0, 1'b0, 32'h104, 0));
      vq.push_back(mk("bgeu_nt",BR,  3'd7, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h20, 32'h100, 4'd14, 32'd0, 1'b0, 32'h104, 0));
      vq.push_back(mk("beq_t",  BR,  3'd0, 1'b0, 1'b0, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h500, 4'd15, 32'd0, 1'b1, 32'h4F0, 0));
      vq.push_back(mk("mul",    OP,  3'd0, 1'b0, 1'b1, 32'd6, 32'd7, 0, 32'h300, 4'd1, 32'd42, 1'b0, 32'h304, MUL_LAT-1));
      vq.push_back(mk("mulh",   OP,  3'd1, 1'b0, 1'b1, 32'h8000_0000, 32'd2, 0, 32'h300, 4'd2, 32'hFFFF_FFFF, 1'b0, 32'h304, MUL_LAT-1));
      vq.push_back(mk("mulhsu", OP,  3'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h300, 4'd3, 32'hFFFF_FFFF, 1'b0, 32'h304, MUL_LAT-1));
      vq.push_back(mk("mulhu",  OP,  3'd3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h300, 4'd4, 32'hFFFF_FFFE, 1'b0, 32'h304, MUL_LAT-1));
      vq.push_back(mk("div_0",  OP,  3'd4, 1'b0, 1'b1, 32'd7, 32'd0, 0, 32'h300, 4'd5, 32'hFFFF_FFFF, 1'b0, 32'h304, DIV_LAT));
      vq.push_back(mk("divn_0", OP,  3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd0, 0, 32'h300, 4'd6, 32'hFFFF_FFFF, 1'b0, 32'h304, DIV_LAT));
      vq.push_back(mk("rem_0",  OP,  3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd0, 0, 32'h300, 4'd7, 32'hFFFF_FFF9, 1'b0, 32'h304, DIV_LAT));
      vq.push_back(mk("rem_neg",OP,  3'd6, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'h300, 4'd8, 32'hFFFF_FFFF, 1'b0, 32'h304, DIV_LAT));
      vq.push_back(mk("div_neg",OP,  3'd4, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'h300, 4'd9, 32'hFFFF_FFFD, 1'b0, 32'h304, DIV_LAT));
      vq.push_back(mk("div_ovf",OP,  3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h300, 4'd10, 32'h8000_0000, 1'b0, 32'h304, DIV_LAT));
      vq.push_back(mk("rem_ovf",OP,  3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h300, 4'd11, 32'd0, 1'b0, 32'h304, DIV_LAT));
      vq.push_back(mk("divu",   OP,  3'd5, 1'b0, 1'b1, 32'd100, 32'd7, 0, 32'h300, 4'd12, 32'd14, 1'b0, 32'h304, DIV_LAT));
      vq.push_back(mk("remu",   OP,  3'd7, 1'b0, 1'b1, 32'd100, 32'd7, 0, 32'h300, 4'd13, 32'd2, 1'b0, 32'h304, DIV_LAT));

      // Reset state
      step();
      step();
      chk("rst result", 32'(bus.result), 32'd0);
      chk("rst val", bus.result_val, 32'd0);
      chk("rst rob", 32'(bus.result_rob_pos), 32'd0);
      chk("rst jump", 32'(bus.result_jump), 32'd0);
      chk("rst pc", bus.result_pc, 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      step();

      foreach (vq[i]) run_vec(vq[i]);

      // MULH busy window: combinational busy at dispatch, then MUL_LAT-1 cycles in MUL
      drive(vq[16]);
      bus.in_en = 1'b1;
      #1;
      chk("mulh busy_dispatch", 32'(bus.busy), 32'd1);
      step();
      bus.in_en = 1'b0;
      cnt = 0;
      e = 0;
      while (!bus.result && e < 20) begin
         if (bus.busy) cnt++;
         step();
         e++;
      end
      chk("mulh busy_cycles", 32'(cnt), 32'(MUL_LAT - 1));
      chk("mulh busy_at_result", 32'(bus.busy), 32'd0);
      chk("mulh val", bus.result_val, 32'hFFFF_FFFF);
      step();

      // DIV with an ignored dispatch while busy and rdy low for 5 edges
      drive(vq[26]);
      bus.in_rob_pos = 4'd3;
      bus.in_en = 1'b1;
      step();
      drive(vq[0]);
      bus.in_rob_pos = 4'd9;
      step();
      bus.in_en = 1'b0;
      chk("div ignored_dispatch", 32'(bus.result), 32'd0);
      step(); step(); step();
      bus.rdy = 1'b0;
      for (int k = 0; k < 5; k++) step();
      bus.rdy = 1'b1;
      wait_result(9, 80, e);
      chk("div_rdy latency", 32'(e), 32'd38);
      chk("div_rdy val", bus.result_val, 32'd14);
      chk("div_rdy rob", 32'(bus.result_rob_pos), 32'd3);
      step();
      chk("div_rdy pulse_end", 32'(bus.result), 32'd0);

      // Rollback of an in-flight DIV at cycle 10
      drive(vq[19]);
      bus.in_en = 1'b1;
      step();
      bus.in_en = 1'b0;
      for (int k = 0; k < 10; k++) step();
      bus.rollback = 1'b1;
      step();
      bus.rollback = 1'b0;
      chk("rollback busy", 32'(bus.busy), 32'd0);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.result) cnt++;
         step();
      end
      chk("rollback no_result", 32'(cnt), 32'd0);

      // Rollback and dispatch together: op dropped
      drive(vq[0]);
      bus.in_en = 1'b1;
      bus.rollback = 1'b1;
      step();
      bus.in_en = 1'b0;
      bus.rollback = 1'b0;
      chk("rollback_dispatch result", 32'(bus.result), 32'd0);

      // Reset mid-MUL returns to reset values immediately
      v = vq[15];
      drive(v);
      bus.in_en = 1'b1;
      step();
      bus.in_en = 1'b0;
      chk("mul_rst busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("mul_rst busy", 32'(bus.busy), 32'd0);
      chk("mul_rst val", bus.result_val, 32'd0);
      chk("mul_rst pc", bus.result_pc, 32'd0);
      step();
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (bus.result) cnt++;
         step();
      end
      chk("mul_rst no_result", 32'(cnt), 32'd0);
      run_vec(vq[10]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
